// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern and saturating match count.
// Optional build macro SEQ_DETECTOR_MASK_EN adds a per-bit don't-care mask loaded alongside the pattern.
module seq_detector_param #(
  parameter int unsigned              PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]       RST_PAT = 4'b1101,
  parameter int unsigned              CNT_W   = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               din,
  input  logic               din_vld,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
`ifdef SEQ_DETECTOR_MASK_EN
  input  logic [PAT_LEN-1:0] pat_mask_in,
`endif
  input  logic               cnt_clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               hist_full
);

  localparam int unsigned          FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] r_pat, r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_dout, r_hist_full;
  logic [CNT_W-1:0]   r_cnt;
`ifdef SEQ_DETECTOR_MASK_EN
  logic [PAT_LEN-1:0] r_mask, w_mask_nx;
`endif

  logic [PAT_LEN-1:0] w_hist_nx, w_diff, w_pat_nx, w_hist_d;
  logic [FILL_W-1:0]  w_fill_inc, w_fill_d;
  logic               w_hit, w_dout_d;
  logic [CNT_W-1:0]   w_cnt_d;

  assign w_hist_nx  = {r_hist[PAT_LEN-2:0], din};
  assign w_fill_inc = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
`ifdef SEQ_DETECTOR_MASK_EN
  assign w_diff = (w_hist_nx ^ r_pat) & r_mask;
`else
  assign w_diff = w_hist_nx ^ r_pat;
`endif
  // A hit only exists for a bit that is actually accepted; pat_load discards the bit.
  assign w_hit = din_vld && !pat_load && (w_fill_inc == FILL_MAX) && (w_diff == '0);

  always_comb begin
    w_pat_nx = r_pat;
    w_hist_d = r_hist;
    w_fill_d = r_fill;
    w_dout_d = 1'b0;
    w_cnt_d  = r_cnt;
`ifdef SEQ_DETECTOR_MASK_EN
    w_mask_nx = r_mask;
`endif
    if (pat_load) begin
      w_pat_nx = pat_in;
      w_hist_d = '0;
      w_fill_d = '0;
`ifdef SEQ_DETECTOR_MASK_EN
      w_mask_nx = pat_mask_in;
`endif
    end else if (din_vld) begin
      w_hist_d = w_hist_nx;
      w_dout_d = w_hit;
      w_fill_d = (w_hit && !overlap) ? '0 : w_fill_inc;
    end
    if (cnt_clr)
      w_cnt_d = '0;
    else if (w_hit && (r_cnt != '1))
      w_cnt_d = r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_pat       <= RST_PAT;
      r_hist      <= '0;
      r_fill      <= '0;
      r_dout      <= 1'b0;
      r_cnt       <= '0;
      r_hist_full <= 1'b0;
`ifdef SEQ_DETECTOR_MASK_EN
      r_mask      <= '1;
`endif
    end else begin
      r_pat       <= w_pat_nx;
      r_hist      <= w_hist_d;
      r_fill      <= w_fill_d;
      r_dout      <= w_dout_d;
      r_cnt       <= w_cnt_d;
      r_hist_full <= (w_fill_d == FILL_MAX);
`ifdef SEQ_DETECTOR_MASK_EN
      r_mask      <= w_mask_nx;
`endif
    end
  end

  assign dout      = r_dout;
  assign match_cnt = r_cnt;
  assign hist_full = r_hist_full;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus randomized traffic
// checked against a queue-based reference model; two instances (8-bit and 2-bit counters).
module tb_seq_detector_param;

  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          clr_n, din, din_vld, overlap, pat_load, cnt_clr;
  logic [PL-1:0] pat_in;
`ifdef SEQ_DETECTOR_MASK_EN
  logic [PL-1:0] pat_mask_in;
`endif
  logic          dout_a, dout_b, full_a, full_b;
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b;

  seq_detector_param #(.PAT_LEN(4), .RST_PAT(4'b1101), .CNT_W(8)) u_dut_a (
    .clk(clk), .clr_n(clr_n), .din(din), .din_vld(din_vld), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DETECTOR_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .cnt_clr(cnt_clr), .dout(dout_a), .match_cnt(cnt_a), .hist_full(full_a));

  seq_detector_param #(.PAT_LEN(4), .RST_PAT(4'b1101), .CNT_W(2)) u_dut_b (
    .clk(clk), .clr_n(clr_n), .din(din), .din_vld(din_vld), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DETECTOR_MASK_EN
    .pat_mask_in(pat_mask_in),
`endif
    .cnt_clr(cnt_clr), .dout(dout_b), .match_cnt(cnt_b), .hist_full(full_b));

  always #5 clk = ~clk;

  // Reference model: the accepted bits since the last reset/load/non-overlap match.
  bit          q[$];
  logic [PL-1:0] m_pat, m_mask;
  int          m_cnt_a, m_cnt_b;
  bit          m_dout;
  int          n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model(input bit rn, vld, d, ovl, ld, cc, input logic [PL-1:0] pin, pmask);
    bit hit;
    hit = 1'b0;
    if (!rn) begin
      m_pat = 4'b1101; m_mask = '1; q.delete(); m_dout = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      if (ld) begin
        m_pat = pin; m_mask = pmask; q.delete();
      end else if (vld) begin
        q.push_back(d);
        if (q.size() > PL) void'(q.pop_front());
        if (q.size() == PL) begin
          hit = 1'b1;
          for (int k = 0; k < PL; k++)
            if (m_mask[PL-1-k] && (q[k] != m_pat[PL-1-k])) hit = 1'b0;
        end
        if (hit && !ovl) q.delete();
      end
      m_dout = hit;
      if (cc) begin
        m_cnt_a = 0; m_cnt_b = 0;
      end else if (hit) begin
        m_cnt_a = (m_cnt_a + 1 > 255) ? 255 : m_cnt_a + 1;
        m_cnt_b = (m_cnt_b + 1 > 3) ? 3 : m_cnt_b + 1;
      end
    end
  endtask

  task automatic step(input bit rn, vld, d, ovl, ld, cc,
                      input logic [PL-1:0] pin, input logic [PL-1:0] pmask = '1);
    clr_n = rn; din_vld = vld; din = d; overlap = ovl; pat_load = ld; cnt_clr = cc; pat_in = pin;
`ifdef SEQ_DETECTOR_MASK_EN
    pat_mask_in = pmask;
`endif
    @(posedge clk);
`ifdef SEQ_DETECTOR_MASK_EN
    model(rn, vld, d, ovl, ld, cc, pin, pmask);
`else
    model(rn, vld, d, ovl, ld, cc, pin, '1);
`endif
    #1;
    check("dout_a", 32'(dout_a), 32'(m_dout));
    check("dout_b", 32'(dout_b), 32'(m_dout));
    check("cnt_a",  32'(cnt_a),  32'(m_cnt_a));
    check("cnt_b",  32'(cnt_b),  32'(m_cnt_b));
    check("full_a", 32'(full_a), 32'(q.size() == PL));
    check("full_b", 32'(full_b), 32'(q.size() == PL));
  endtask

  task automatic bit_in(input bit d, input bit ovl);
    step(1, 1, d, ovl, 0, 0, '0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    logic [6:0] s7;
    s7 = 7'b1101101;

    // Reset state.
    do_reset();
    check("rst_dout", 32'(dout_a), 0);
    check("rst_cnt", 32'(cnt_a), 0);
    check("rst_full", 32'(full_a), 0);

    // Overlapping: 1,1,0,1,1,0,1 -> pulses after bits 4 and 7.
    for (int i = 6; i >= 0; i--) begin
      bit_in(s7[i], 1);
      check("ovl_dout", 32'(dout_a), 32'((i == 3) || (i == 0)));
    end
    check("ovl_cnt", 32'(cnt_a), 2);

    // Non-overlapping: single pulse, hist_full drops with it.
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      bit_in(s7[i], 0);
      check("novl_dout", 32'(dout_a), 32'(i == 3));
      if (i == 3) check("novl_full_drop", 32'(full_a), 0);
    end
    check("novl_cnt", 32'(cnt_a), 1);

    // Gapped valid: junk bits while din_vld low are ignored.
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] p;
      p = 4'b1101;
      bit_in(p[i], 1);
      check("gap_dout", 32'(dout_a), 32'(i == 0));
      for (int g = 0; g < 3; g++) begin
        step(1, 0, ~p[i], 1, 0, 0, '0);
        check("gap_idle", 32'(dout_a), 0);
      end
    end
    check("gap_cnt", 32'(cnt_a), 1);

    // pat_load with a simultaneous valid bit: bit discarded, new pattern 0110.
    do_reset();
    step(1, 1, 0, 1, 1, 0, 4'b0110);
    check("load_full", 32'(full_a), 0);
    bit_in(1, 1); bit_in(1, 1); bit_in(0, 1);
    check("load_nofalse", 32'(dout_a), 0);
    bit_in(1, 1);
    check("old_pat_dead", 32'(dout_a), 0);
    bit_in(1, 1); bit_in(0, 1);
    check("new_pat_hit", 32'(dout_a), 1);

    // Saturation on the 2-bit counter, then clear colliding with a hit.
    do_reset();
    step(1, 0, 0, 1, 1, 0, 4'b1111);
    for (int i = 0; i < 7; i++) bit_in(1, 1);
    check("sat_cnt_b", 32'(cnt_b), 3);
    check("sat_cnt_a", 32'(cnt_a), 4);
    step(1, 1, 1, 1, 0, 1, '0);
    check("clr_hit_dout", 32'(dout_b), 1);
    check("clr_hit_cnt", 32'(cnt_b), 0);

    // Reset mid-stream discards the partial match and restores 1101.
    do_reset();
    step(1, 0, 0, 1, 1, 0, 4'b0000);
    bit_in(1, 1); bit_in(1, 1); bit_in(0, 1);
    do_reset();
    bit_in(1, 1);
    check("midrst_dout", 32'(dout_a), 0);
    bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
    check("rst_pat_back", 32'(dout_a), 1);

`ifdef SEQ_DETECTOR_MASK_EN
    // Mask bit 1 don't-care: 1111 matches pattern 1101.
    do_reset();
    step(1, 0, 0, 1, 1, 0, 4'b1101, 4'b1101);
    for (int i = 0; i < 4; i++) bit_in(1, 1);
    check("mask_hit", 32'(dout_a), 1);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [PL-1:0] rp, rm;
      rp = PL'($urandom);
      rm = ($urandom_range(0, 3) == 0) ? PL'($urandom) : '1;
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 5) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 29) == 0), rp, rm);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
